// File: rtl/online_mult_pkg.sv
// ---------------------------------------------------------------------------
// online_mult_pkg
// Shared definitions for the radix-2 online multiplier/divider selection
// stages: signed-digit encodings, the digit-counter state type and helpers
// that derive the selection constants from the estimate width.
// No ports (package).
// ---------------------------------------------------------------------------
package online_mult_pkg;

   // Selected digit as {plus, minus}; the pair 2'b11 is never produced.
   localparam logic [1:0] DIG_POS  = 2'b10;
   localparam logic [1:0] DIG_NEG  = 2'b01;
   localparam logic [1:0] DIG_ZERO = 2'b00;

   typedef enum logic [1:0] {
      CNT_IDLE,
      CNT_DELAY,
      CNT_RUN,
      CNT_LAST
   } cnt_state_t;

   // Selection threshold (1/2) in LSB units of a sample_w-bit estimate.
   function automatic int sel_half(input int sample_w);
      return 1 << (sample_w - 3);
   endfunction

   // Weight of one output digit (1.0) in LSB units.
   function automatic int sel_one(input int sample_w);
      return 1 << (sample_w - 2);
   endfunction

endpackage

// File: rtl/online_digit_select_if.sv
// ---------------------------------------------------------------------------
// online_digit_select_if
// Bundles the estimate input handshake and the result output handshake of
// the digit-selection stage.
//   in_valid/in_ready/in_first     : estimate handshake, first-of-operation
//   sample_plus/sample_minus       : borrow-save estimate (SAMPLE_W bits)
//   out_valid/out_ready            : result handshake
//   z_plus/z_minus                 : selected digit
//   upper_plus/upper_minus         : updated residual (SAMPLE_W-1 bits)
//   out_last/ovf                   : final-digit marker, sticky overflow
// Modports: slave = the selection stage, master = whoever drives it.
// ---------------------------------------------------------------------------
interface online_digit_select_if #(
   parameter int SAMPLE_W = 4
);
   logic                in_valid;
   logic                in_ready;
   logic                in_first;
   logic [SAMPLE_W-1:0] sample_plus;
   logic [SAMPLE_W-1:0] sample_minus;
   logic                out_valid;
   logic                out_ready;
   logic                z_plus;
   logic                z_minus;
   logic [SAMPLE_W-2:0] upper_plus;
   logic [SAMPLE_W-2:0] upper_minus;
   logic                out_last;
   logic                ovf;

   modport slave (
      input  in_valid, in_first, sample_plus, sample_minus, out_ready,
      output in_ready, out_valid, z_plus, z_minus, upper_plus, upper_minus,
             out_last, ovf
   );

   modport master (
      output in_valid, in_first, sample_plus, sample_minus, out_ready,
      input  in_ready, out_valid, z_plus, z_minus, upper_plus, upper_minus,
             out_last, ovf
   );
endinterface

// File: rtl/sd_select_comb.sv
// ---------------------------------------------------------------------------
// sd_select_comb
// Purely combinational radix-2 signed-digit selection:
//   p = +1 if v >= 1/2, p = -1 if v < -1/2, else 0;  w = v - p.
// Ports:
//   v : SAMPLE_W-bit two's-complement estimate, LSB weight 2^-(SAMPLE_W-2)
//   p : selected digit as {plus, minus}
//   w : residual, SAMPLE_W-1 signed bits (always fits once p is applied)
// ---------------------------------------------------------------------------
module sd_select_comb
   import online_mult_pkg::*;
#(
   parameter int SAMPLE_W = 4
) (
   input  logic [SAMPLE_W-1:0] v,
   output logic [1:0]          p,
   output logic [SAMPLE_W-2:0] w
);

   localparam logic [SAMPLE_W-1:0] HALF_V  = SAMPLE_W'(sel_half(SAMPLE_W));
   localparam logic [SAMPLE_W-1:0] NHALF_V = SAMPLE_W'(-sel_half(SAMPLE_W));
   localparam logic [SAMPLE_W-2:0] ONE_W   = (SAMPLE_W-1)'(sel_one(SAMPLE_W));

   // The residual only needs SAMPLE_W-1 bits, so the subtraction is done
   // modulo 2^(SAMPLE_W-1) on the low bits of v.
   always_comb begin
      p = DIG_ZERO;
      w = v[SAMPLE_W-2:0];
      if ($signed(v) >= $signed(HALF_V)) begin
         p = DIG_POS;
         w = v[SAMPLE_W-2:0] - ONE_W;
      end else if ($signed(v) < $signed(NHALF_V)) begin
         p = DIG_NEG;
         w = v[SAMPLE_W-2:0] + ONE_W;
      end
   end

endmodule

// File: rtl/online_digit_select.sv
// ---------------------------------------------------------------------------
// online_digit_select
// Two-stage pipelined digit-selection stage of the radix-2 online
// multiplier. Accepts one borrow-save residual estimate per cycle, returns
// the selected digit and the updated residual upper bits in borrow-save
// form, forces the first DELTA digits of each operation to zero, marks the
// final digit and keeps a sticky overflow flag.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : online_digit_select_if.slave (handshakes, data, flags)
// ---------------------------------------------------------------------------
module online_digit_select
   import online_mult_pkg::*;
#(
   parameter int SAMPLE_W = 4,
   parameter int DELTA    = 3,
   parameter int N_DIGITS = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   online_digit_select_if.slave bus
);

   localparam int LAST_I = DELTA + N_DIGITS - 1;
   localparam int CW     = (DELTA + N_DIGITS > 1) ? $clog2(DELTA + N_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(LAST_I);

   // ---------------- handshake -------------------------------------------
   logic in_ready;
   logic accept;
   logic s2_adv;

   logic                s1_valid_reg;
   logic [SAMPLE_W-1:0] s1_v_reg;
   logic                s1_forced_reg;
   logic                s1_last_reg;
   logic                s1_first_reg;

   logic                s2_valid_reg;
   logic [1:0]          s2_digit_reg;
   logic [SAMPLE_W-2:0] s2_w_reg;
   logic                s2_last_reg;
   logic                ovf_reg;

   assign in_ready     = !s1_valid_reg || !s2_valid_reg || bus.out_ready;
   assign bus.in_ready = in_ready;
   assign accept       = bus.in_valid && in_ready;
   // S1 moves into S2 whenever S2 is empty or is being drained this cycle.
   assign s2_adv       = s1_valid_reg && (!s2_valid_reg || bus.out_ready);

   // ---------------- digit counter FSM -----------------------------------
   cnt_state_t    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [CW-1:0] cur_cnt;
   logic          est_forced;
   logic          est_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= CNT_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // cur_cnt is the position of the estimate currently offered. Without an
   // in_first, an estimate seen in IDLE is handled as position 0 but does not
   // start an operation; only in_first leaves IDLE.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cur_cnt    = '0;
      est_forced = 1'b0;
      est_last   = 1'b0;

      if (bus.in_first || state_reg == CNT_IDLE) begin
         cur_cnt = '0;
      end else if (cnt_reg == CNT_MAX) begin
         cur_cnt = CNT_MAX;
      end else begin
         cur_cnt = cnt_reg + CW'(1);
      end

      est_forced = int'(cur_cnt) < DELTA;
      // Once the final digit has gone out, saturated repeats are not last.
      est_last   = (cur_cnt == CNT_MAX) && (bus.in_first || state_reg != CNT_LAST);

      if (accept) begin
         cnt_next = cur_cnt;
         if (bus.in_first || state_reg != CNT_IDLE) begin
            if (est_forced) begin
               state_next = CNT_DELAY;
            end else if (cur_cnt == CNT_MAX) begin
               state_next = CNT_LAST;
            end else begin
               state_next = CNT_RUN;
            end
         end
      end
   end

   // ---------------- stage 1: estimate and flags -------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg  <= 1'b0;
         s1_v_reg      <= '0;
         s1_forced_reg <= 1'b0;
         s1_last_reg   <= 1'b0;
         s1_first_reg  <= 1'b0;
      end else if (accept) begin
         s1_valid_reg  <= 1'b1;
         s1_v_reg      <= bus.sample_plus - bus.sample_minus;
         s1_forced_reg <= est_forced;
         s1_last_reg   <= est_last;
         s1_first_reg  <= bus.in_first;
      end else if (s2_adv) begin
         s1_valid_reg  <= 1'b0;
      end
   end

   // ---------------- selection -------------------------------------------
   logic [1:0]          sel_p;
   logic [SAMPLE_W-2:0] sel_w;
   logic                ovf_hit;

   sd_select_comb #(
      .SAMPLE_W (SAMPLE_W)
   ) u_select (
      .v (s1_v_reg),
      .p (sel_p),
      .w (sel_w)
   );

   // A forced zero keeps w = v, which only fits when the top two bits agree.
   assign ovf_hit = s1_forced_reg && (s1_v_reg[SAMPLE_W-1] != s1_v_reg[SAMPLE_W-2]);

   // ---------------- stage 2: digit, residual, flags ---------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         s2_digit_reg <= DIG_ZERO;
         s2_w_reg     <= '0;
         s2_last_reg  <= 1'b0;
         ovf_reg      <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_reg <= 1'b1;
         s2_digit_reg <= s1_forced_reg ? DIG_ZERO : sel_p;
         s2_w_reg     <= s1_forced_reg ? s1_v_reg[SAMPLE_W-2:0] : sel_w;
         s2_last_reg  <= s1_last_reg;
         // Setting wins over the clear carried by in_first.
         ovf_reg      <= ovf_hit || (ovf_reg && !s1_first_reg);
      end else if (bus.out_ready) begin
         s2_valid_reg <= 1'b0;
      end
   end

   // ---------------- outputs ---------------------------------------------
   // Borrow-save split: magnitude bits in plus, sign bit (negative weight)
   // alone in minus.
   assign bus.out_valid   = s2_valid_reg;
   assign bus.z_plus      = s2_digit_reg[1];
   assign bus.z_minus     = s2_digit_reg[0];
   assign bus.upper_plus  = {1'b0, s2_w_reg[SAMPLE_W-3:0]};
   assign bus.upper_minus = {s2_w_reg[SAMPLE_W-2], {(SAMPLE_W-2){1'b0}}};
   assign bus.out_last    = s2_last_reg;
   assign bus.ovf         = ovf_reg;

endmodule

// File: tb/tb_online_digit_select.sv
// ---------------------------------------------------------------------------
// tb_online_digit_select
// Drives one shared estimate stream into three instances (DELTA/N_DIGITS of
// 0/16, 3/4 and 2/16, all SAMPLE_W=4) and scores every result against a
// per-instance reference model queue.
// ---------------------------------------------------------------------------
module tb_online_digit_select;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_first = 1'b0;
   logic       out_ready = 1'b1;
   logic [3:0] sample_plus = '0;
   logic [3:0] sample_minus = '0;

   logic [9:0] dut_out [3];
   logic       dut_valid [3];
   logic       dut_rdy [3];
   logic       dut_ovf [3];

   int n_checks = 0;
   int n_errors = 0;
   int n_last1  = 0;

   logic [9:0] sb0 [$];
   logic [9:0] sb1 [$];
   logic [9:0] sb2 [$];

   int delta_of [3] = '{0, 3, 2};
   int max_of   [3] = '{15, 6, 17};
   int m_cnt    [3] = '{0, 0, 0};
   bit m_active [3] = '{0, 0, 0};
   bit m_atend  [3] = '{0, 0, 0};
   bit m_ovf    [3] = '{0, 0, 0};

   bit         prev_stall [3] = '{0, 0, 0};
   logic [9:0] prev_out   [3];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int DL = (gi == 0) ? 0 : ((gi == 1) ? 3 : 2);
      localparam int ND = (gi == 1) ? 4 : 16;

      online_digit_select_if #(.SAMPLE_W(4)) dut_bus ();

      assign dut_bus.in_valid     = in_valid;
      assign dut_bus.in_first     = in_first;
      assign dut_bus.sample_plus  = sample_plus;
      assign dut_bus.sample_minus = sample_minus;
      assign dut_bus.out_ready    = out_ready;

      online_digit_select #(
         .SAMPLE_W (4),
         .DELTA    (DL),
         .N_DIGITS (ND)
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (dut_bus.slave)
      );

      assign dut_out[gi]   = {dut_bus.z_plus, dut_bus.z_minus, dut_bus.upper_plus,
                              dut_bus.upper_minus, dut_bus.out_last, dut_bus.ovf};
      assign dut_valid[gi] = dut_bus.out_valid;
      assign dut_rdy[gi]   = dut_bus.in_ready;
      assign dut_ovf[gi]   = dut_bus.ovf;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input int i, input logic [9:0] e);
      case (i)
         0:       sb0.push_back(e);
         1:       sb1.push_back(e);
         default: sb2.push_back(e);
      endcase
   endtask

   function automatic int sb_size(input int i);
      case (i)
         0:       return sb0.size();
         1:       return sb1.size();
         default: return sb2.size();
      endcase
   endfunction

   task automatic sb_pop(input int i, output logic [9:0] e);
      case (i)
         0:       e = sb0.pop_front();
         1:       e = sb1.pop_front();
         default: e = sb2.pop_front();
      endcase
   endtask

   // Reference model for one accepted estimate on instance i.
   task automatic model_push(input int i, input bit f, input logic [3:0] sp, input logic [3:0] sm);
      logic [3:0] d;
      logic [2:0] wb;
      int v, pd, w, c;
      bit forced, last, hit;
      d = sp - sm;
      v = d[3] ? int'(d) - 16 : int'(d);
      if (f || !m_active[i])        c = 0;
      else if (m_cnt[i] < max_of[i]) c = m_cnt[i] + 1;
      else                          c = max_of[i];
      last   = (c == max_of[i]) && (f || !m_atend[i]);
      forced = c < delta_of[i];
      if (forced)       pd = 0;
      else if (v >= 2)  pd = 1;
      else if (v < -2)  pd = -1;
      else              pd = 0;
      w   = v - 4 * pd;
      hit = forced && (v < -4 || v > 3);
      if (hit)    m_ovf[i] = 1'b1;
      else if (f) m_ovf[i] = 1'b0;
      if (f) m_active[i] = 1'b1;
      m_cnt[i]   = c;
      m_atend[i] = m_active[i] && (c == max_of[i]);
      wb = 3'(w);
      sb_push(i, {(pd == 1), (pd == -1), 1'b0, wb[1:0], wb[2], 2'b00, last, m_ovf[i]});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0; m_active[i] = 0; m_atend[i] = 0; m_ovf[i] = 0;
      end
      sb0.delete(); sb1.delete(); sb2.delete();
   endtask

   // Monitor: sampled on the falling edge, away from DUT updates.
   always @(negedge clk) begin
      logic [9:0] e;
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) prev_stall[i] = 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (prev_stall[i])
               check($sformatf("hold_u%0d", i), {dut_valid[i], dut_out[i]}, {1'b1, prev_out[i]});
            if (dut_valid[i] && out_ready) begin
               if (sb_size(i) == 0) begin
                  check($sformatf("spurious_u%0d", i), 1, 0);
               end else begin
                  sb_pop(i, e);
                  $display("u%0d result %03h expect %03h", i, dut_out[i], e);
                  check($sformatf("res_u%0d", i), dut_out[i], e);
                  if (i == 1 && dut_out[1][1]) n_last1++;
               end
            end
            prev_stall[i] = dut_valid[i] && !out_ready;
            prev_out[i]   = dut_out[i];
            if (in_valid && dut_rdy[i]) model_push(i, in_first, sample_plus, sample_minus);
         end
      end
   end

   // All tasks below start and end 1 time unit after a rising edge.
   task automatic send(input bit f, input logic [3:0] sp, input logic [3:0] sm);
      bit ok = 1'b0;
      in_valid = 1'b1; in_first = f; sample_plus = sp; sample_minus = sm;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (dut_rdy[0]) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_first = 1'b0;
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic drain();
      bit ok = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if (sb0.size() == 0 && sb1.size() == 0 && sb2.size() == 0) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      check("drain_timeout", ok, 1);
   endtask

   logic [3:0] st_p [6] = '{4'd3, 4'd0, 4'd2, 4'd0, 4'd3, 4'd1};
   logic [3:0] st_m [6] = '{4'd0, 4'd3, 4'd0, 4'd1, 4'd1, 4'd0};

   initial begin
      int idx;
      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_out_u%0d", i), dut_out[i], 0);
         check($sformatf("rst_valid_u%0d", i), dut_valid[i], 0);
         check($sformatf("rst_ready_u%0d", i), dut_rdy[i], 1);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ---- latency and basic selection (v=3, -3, -2, 1) ----
      send(1'b1, 4'b0011, 4'b0000);
      check("lat_not_yet", dut_valid[0], 0);
      @(posedge clk); #1;
      check("lat_valid", dut_valid[0], 1);
      check("lat_value", dut_out[0], 10'b1_0_011_100_0_0);
      send(1'b0, 4'b0000, 4'b0011);
      send(1'b0, 4'b0000, 4'b0010);
      send(1'b0, 4'b0001, 4'b0000);
      drain();

      // ---- one full operation on the DELTA=3/N=4 instance, then overrun ----
      n_last1 = 0;
      send(1'b1, 4'd3, 4'd0);
      for (int k = 0; k < 8; k++) send(1'b0, 4'd3, 4'd0);
      drain();
      check("last_count_u1", n_last1, 1);

      // ---- backpressure: out_ready low for 5 cycles ----
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_first = (idx == 0);
         sample_plus = st_p[idx]; sample_minus = st_m[idx];
         @(negedge clk);
         if (dut_rdy[0]) idx++;
         @(posedge clk); #1;
      end
      check("stall_accepts", idx, 2);
      check("stall_ready", dut_rdy[0], 0);
      out_ready = 1'b1;
      for (int k = idx; k < 6; k++) send(1'b0, st_p[k], st_m[k]);
      drain();

      // ---- sticky overflow on a forced-zero estimate ----
      send(1'b1, 4'd5, 4'd0);
      for (int k = 0; k < 3; k++) send(1'b0, 4'd1, 4'd0);
      drain();
      check("ovf_sticky_u2", dut_ovf[2], 1);
      send(1'b1, 4'd0, 4'd0);
      drain();
      check("ovf_clear_u2", dut_ovf[2], 0);

      // ---- random stream with random backpressure ----
      for (int k = 0; k < 80; k++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         in_first     = ($urandom_range(0, 7) == 0);
         sample_plus  = 4'($urandom_range(0, 15));
         sample_minus = 4'($urandom_range(0, 15));
         out_ready    = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      drain();

      // ---- reset in the middle of a stream ----
      send(1'b1, 4'd5, 4'd0);
      send(1'b0, 4'd1, 4'd0);
      send(1'b0, 4'd2, 4'd0);
      check("pre_rst_ovf_u2", dut_ovf[2], 1);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("mid_rst_valid_u%0d", i), dut_valid[i], 0);
         check($sformatf("mid_rst_ovf_u%0d", i), dut_ovf[i], 0);
         check($sformatf("mid_rst_ready_u%0d", i), dut_rdy[i], 1);
      end
      @(posedge clk); @(posedge clk); #1;
      model_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(1'b0, 4'd3, 4'd0);
      send(1'b1, 4'd0, 4'd3);
      send(1'b0, 4'd7, 4'd0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/online_digit_select.md
# online_digit_select

Parametrised, pipelined digit-selection stage for the radix-2 online multiplier. Each cycle it accepts one residual estimate in borrow-save (plus/minus) form. It returns the selected output digit p ∈ {−1,0,+1} and the updated residual upper bits, also in borrow-save form. It enforces the online delay, flags the last digit of an operation, and supports valid/ready backpressure. It sits between the residual adder and the residual register of the multiplier recurrence.

## Interface
- SAMPLE_W, 4, estimate width in bits; must be ≥4; LSB weight 2^−(SAMPLE_W−2)
- DELTA, 3, online delay: number of leading digits forced to 0 per operation
- N_DIGITS, 16, significant output digits per operation
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  estimate present
- in_ready  out  1  stage can accept an estimate
- in_first  in  1  qualifies the first estimate of a new operation
- sample_plus  in  SAMPLE_W  positive estimate vector
- sample_minus  in  SAMPLE_W  negative estimate vector
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- z_plus, z_minus  out  1 each  selected digit: (1,0)=+1, (0,1)=−1, (0,0)=0; (1,1) is never driven
- upper_plus  out  SAMPLE_W−1  updated residual, positive vector
- upper_minus  out  SAMPLE_W−1  updated residual, negative vector
- out_last  out  1  result carries the final digit of the operation
- ovf  out  1  sticky overflow flag

## Operation
- Handshake: a transfer occurs when valid and ready are both high in the same cycle.
- Estimate: v = sample_plus − sample_minus, SAMPLE_W-bit two's-complement subtraction; wrap-around is accepted.
- Selection constants: HALF = 2^(SAMPLE_W−3) and ONE = 2^(SAMPLE_W−2), in LSB units.
- Selection rule:
  - p = +1 if v ≥ HALF
  - p = −1 if v < −HALF
  - otherwise p = 0
- Online delay: for the first DELTA accepted estimates of an operation, p is forced to 0.
- Residual: w = v − p·ONE.
  - When p is not forced, w always fits in SAMPLE_W−1 signed bits.
- Output encoding:
  - upper_plus = {1'b0, w[SAMPLE_W−3:0]}
  - upper_minus = {w[SAMPLE_W−2], (SAMPLE_W−2)'b0}
  - The MSB carries negative weight in the minus vector.
- Digit counter:
  - in_first on an accepted estimate loads the count to 0 for that estimate.
  - Otherwise the count increments on each accepted estimate.
  - The count saturates at DELTA+N_DIGITS−1.
  - Estimates arriving after the final digit without in_first are processed with out_last=0.
- out_last = 1 exactly when count = DELTA+N_DIGITS−1.
- ovf:
  - Set when a forced-zero estimate has v outside [−2^(SAMPLE_W−2), 2^(SAMPLE_W−2)−1]; w is truncated in that case.
  - Cleared only by an accepted in_first estimate or by reset.
  - If an in_first estimate itself overflows, ovf is set (set wins).
- Counter state machine states:
  - IDLE: no operation started. Estimates accepted without in_first are treated as count 0.
  - DELAY: count < DELTA.
  - RUN: DELTA ≤ count < DELTA+N_DIGITS−1.
  - LAST: count = DELTA+N_DIGITS−1.
  - From any state, in_first forces entry to DELAY (or RUN when DELTA=0).

## Timing
- Pipeline: two register stages.
  - S1 registers v, the forced-zero flag and the last flag.
  - S2 registers p, w, out_last and the ovf update.
- Latency: 2 cycles from input transfer to out_valid when there is no stall.
- Throughput: 1 estimate per cycle.
- in_ready = !s1_valid || !s2_valid || out_ready. Combinational; it never depends on in_valid.
- Stall: when out_valid && !out_ready, all outputs hold stable and S1 holds. No estimate is lost or duplicated.
- Simultaneous S2 drain and S1 fill: S1 advances into S2 in the same cycle.
- Reset (any time, including mid-operation): all valid bits are cleared and the counter returns to IDLE. Output values under reset:
  - in_ready=1
  - out_valid=0, z_plus=0, z_minus=0, out_last=0, ovf=0
  - upper_plus=0, upper_minus=0
- In-flight data is discarded on reset.

## Structure
- Shared package `online_mult_pkg`:
  - digit encoding constants (DIG_POS, DIG_NEG, DIG_ZERO)
  - counter state enum
  - HALF/ONE helper functions of SAMPLE_W
- One natural sub-module: `sd_select_comb`. It is purely combinational: v in, p and w out. It is reused by the divider selection stage.
- Counter width: $clog2(DELTA+N_DIGITS).

## Test plan
All scenarios use SAMPLE_W=4, DELTA=0 unless stated.
- plus=0011, minus=0000 (v=3) -> 2 cycles later z=+1, upper_plus=011, upper_minus=100 (w=−1).
- plus=0000, minus=0011 (v=−3) -> z=−1, upper_plus=001, upper_minus=000 (w=1).
- v=−2 (plus=0000, minus=0010) -> z=0, upper_plus=010, upper_minus=100. v=1 -> z=0, upper_plus=001, upper_minus=000.
- DELTA=3, N_DIGITS=4, 7 estimates of v=3 starting with in_first:
  - first 3 results z=0, w=3, ovf=0
  - next 4 results z=+1
  - out_last only on the 7th result
- out_ready held low for 5 cycles with a continuous input stream -> in_ready falls after 2 accepts; no results lost or reordered when released. Reset asserted mid-stream -> out_valid=0 and ovf=0 immediately.
- DELTA=2, forced-zero estimate v=5 -> ovf=1 and stays 1 through later estimates; next accepted in_first with v=0 -> ovf=0.
